// File: rtl/uart_rx_cmd.sv
`timescale 1ns/1ps
// UART 8N1 receiver with a single-byte command decoder that produces query/clear pulses.
// Latency: o_Rx_DV and the command pulses arrive one cycle after the stop-bit sample (the line also passes through SYNC_STAGES flops).
// Backpressure: none; each byte is presented for exactly one cycle and the consumer must take it then.
module uart_rx_cmd #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Frame_Err,
    output logic       o_Query,
    output logic       o_Clear,
    output logic       o_Cmd_Err,
    output logic       o_Armed
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_done;
    logic        frame_bad;

    logic        armed_d;
    logic        query_d;
    logic        clear_d;
    logic        cmd_err_d;

    logic        dv_q;
    logic [7:0]  byte_q;
    logic        ferr_q;
    logic        query_q;
    logic        clear_q;
    logic        cmd_err_q;
    logic        armed_q;

    // Bring the asynchronous line into the clock domain; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];

    // Receiver state, bit timing and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Frame sequencing: mid-start qualification, one sample per bit period, stop check.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!line_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!line_s) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0 after eight samples.
                    shift_d = {line_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (line_s) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (line_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Command decode on the completed byte so its pulses line up with o_Rx_DV.
    always_comb begin
        armed_d   = armed_q;
        query_d   = 1'b0;
        clear_d   = 1'b0;
        cmd_err_d = 1'b0;
        if (byte_done) begin
            case (shift_d)
                8'h51, 8'h71: begin
                    query_d = 1'b1;
                    armed_d = 1'b0;
                end
                8'h43, 8'h63: begin
                    armed_d = 1'b1;
                end
                8'h21: begin
                    if (armed_q) begin
                        clear_d = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                8'h0D, 8'h0A: begin
                    armed_d = armed_q;
                end
                default: begin
                    cmd_err_d = 1'b1;
                    armed_d   = 1'b0;
                end
            endcase
        end else if (frame_bad) begin
            armed_d = 1'b0;
        end
    end

    // Registered outputs: pulses for one cycle, byte and armed level held.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q      <= 1'b0;
            byte_q    <= 8'h00;
            ferr_q    <= 1'b0;
            query_q   <= 1'b0;
            clear_q   <= 1'b0;
            cmd_err_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            dv_q      <= byte_done;
            byte_q    <= byte_done ? shift_d : byte_q;
            ferr_q    <= frame_bad;
            query_q   <= query_d;
            clear_q   <= clear_d;
            cmd_err_q <= cmd_err_d;
            armed_q   <= armed_d;
        end
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Frame_Err = ferr_q;
    assign o_Query     = query_q;
    assign o_Clear     = clear_q;
    assign o_Cmd_Err   = cmd_err_q;
    assign o_Armed     = armed_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_cmd: fast-rate instance for command decoding, default-rate instance for baud tolerance.
// Frames are driven on the serial lines in absolute time; pulses are tallied by a negedge monitor.
// Each scenario task compares tallies and levels against hand-computed constants.
module tb_uart_rx_cmd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic       a_dv, a_ferr, a_query, a_clear, a_cmd_err, a_armed;
    logic [7:0] a_byte;
    logic       b_dv, b_ferr, b_query, b_clear, b_cmd_err, b_armed;
    logic [7:0] b_byte;

    uart_rx_cmd #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .i_Rx_Serial(rx_a),
        .o_Rx_DV(a_dv), .o_Rx_Byte(a_byte), .o_Frame_Err(a_ferr),
        .o_Query(a_query), .o_Clear(a_clear), .o_Cmd_Err(a_cmd_err), .o_Armed(a_armed)
    );

    uart_rx_cmd dut_b (
        .clk(clk), .rst(rst), .i_Rx_Serial(rx_b),
        .o_Rx_DV(b_dv), .o_Rx_Byte(b_byte), .o_Frame_Err(b_ferr),
        .o_Query(b_query), .o_Clear(b_clear), .o_Cmd_Err(b_cmd_err), .o_Armed(b_armed)
    );

    always #5 clk = ~clk;

    localparam real BIT_A = 160.0;

    int total = 0;
    int bad   = 0;

    int dv_a = 0, q_a = 0, c_a = 0, e_a = 0, fe_a = 0, viol_a = 0;
    int dv_b = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    // Tally pulses; flag parser pulses without DV or more than one parser pulse at once.
    always @(negedge clk) begin
        if (a_dv === 1'b1) begin dv_a++; last_a = a_byte; end
        if (a_query === 1'b1) q_a++;
        if (a_clear === 1'b1) c_a++;
        if (a_cmd_err === 1'b1) e_a++;
        if (a_ferr === 1'b1) fe_a++;
        if ((a_query === 1'b1 || a_clear === 1'b1 || a_cmd_err === 1'b1) && a_dv !== 1'b1) viol_a++;
        if (int'(a_query === 1'b1) + int'(a_clear === 1'b1) + int'(a_cmd_err === 1'b1) > 1) viol_a++;
        if (b_dv === 1'b1) begin dv_b++; last_b = b_byte; end
    end

    task automatic send_a(input logic [7:0] b, input logic stop_lvl);
        logic [9:0] f;
        f = {stop_lvl, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_a = f[i];
            #(BIT_A);
        end
    endtask

    task automatic send_b(input logic [7:0] b, input real bit_ns);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_b = f[i];
            #(bit_ns);
        end
        rx_b = 1'b1;
        #(2.0 * bit_ns);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_dv, a_ferr, a_query, a_clear, a_cmd_err, a_armed, a_byte} !== 14'h0) begin
            bad++;
            $display("FAIL reset_a: got %b want all zero", {a_dv, a_ferr, a_query, a_clear, a_cmd_err, a_armed, a_byte});
        end
        total++;
        if ({b_dv, b_ferr, b_query, b_clear, b_cmd_err, b_armed, b_byte} !== 14'h0) begin
            bad++;
            $display("FAIL reset_b: got %b want all zero", {b_dv, b_ferr, b_query, b_clear, b_cmd_err, b_armed, b_byte});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_query;
        int dv0, q0, c0, e0, f0;
        dv0 = dv_a; q0 = q_a; c0 = c_a; e0 = e_a; f0 = fe_a;
        send_a(8'h51, 1'b1);
        total++;
        if (dv_a - dv0 != 1) begin bad++; $display("FAIL query_dv: got %0d want 1", dv_a - dv0); end
        total++;
        if (a_byte !== 8'h51) begin bad++; $display("FAIL query_byte: got %h want 51", a_byte); end
        total++;
        if (q_a - q0 != 1) begin bad++; $display("FAIL query_pulse: got %0d want 1", q_a - q0); end
        total++;
        if ((c_a - c0) + (e_a - e0) + (fe_a - f0) != 0) begin
            bad++; $display("FAIL query_others: got %0d want 0", (c_a - c0) + (e_a - e0) + (fe_a - f0));
        end
    endtask

    task automatic test_arm_clear;
        int c0, e0;
        c0 = c_a; e0 = e_a;
        send_a(8'h43, 1'b1);
        total++;
        if (a_armed !== 1'b1) begin bad++; $display("FAIL arm_after_C: got %b want 1", a_armed); end
        send_a(8'h0D, 1'b1);
        total++;
        if (a_armed !== 1'b1 || c_a != c0) begin
            bad++; $display("FAIL arm_after_CR: armed %b clears %0d want 1 0", a_armed, c_a - c0);
        end
        send_a(8'h21, 1'b1);
        total++;
        if (c_a - c0 != 1) begin bad++; $display("FAIL clear_pulse: got %0d want 1", c_a - c0); end
        total++;
        if (a_armed !== 1'b0 || e_a != e0) begin
            bad++; $display("FAIL clear_disarm: armed %b errs %0d want 0 0", a_armed, e_a - e0);
        end
    endtask

    task automatic test_cmd_err;
        int c0, e0;
        c0 = c_a; e0 = e_a;
        send_a(8'h21, 1'b1);
        total++;
        if (e_a - e0 != 1 || a_armed !== 1'b0) begin
            bad++; $display("FAIL bang_unarmed: errs %0d armed %b want 1 0", e_a - e0, a_armed);
        end
        send_a(8'h63, 1'b1);
        total++;
        if (a_armed !== 1'b1) begin bad++; $display("FAIL arm_after_c: got %b want 1", a_armed); end
        send_a(8'h78, 1'b1);
        total++;
        if (e_a - e0 != 2 || a_armed !== 1'b0) begin
            bad++; $display("FAIL bad_byte_x: errs %0d armed %b want 2 0", e_a - e0, a_armed);
        end
        total++;
        if (c_a != c0) begin bad++; $display("FAIL no_clear: got %0d want 0", c_a - c0); end
    endtask

    task automatic test_frame_err;
        int dv0, f0, e0;
        send_a(8'h43, 1'b1);
        dv0 = dv_a; f0 = fe_a; e0 = e_a;
        send_a(8'hA5, 1'b0);
        rx_a = 1'b0;
        #(40.0 * BIT_A);
        rx_a = 1'b1;
        #(2.0 * BIT_A);
        total++;
        if (fe_a - f0 != 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", fe_a - f0); end
        total++;
        if (dv_a != dv0 || a_byte !== 8'h43) begin
            bad++; $display("FAIL frame_err_byte: dv %0d byte %h want 0 43", dv_a - dv0, a_byte);
        end
        total++;
        if (a_armed !== 1'b0) begin bad++; $display("FAIL frame_err_disarm: got %b want 0", a_armed); end
        send_a(8'h33, 1'b1);
        total++;
        if (dv_a - dv0 != 1 || a_byte !== 8'h33 || e_a - e0 != 1) begin
            bad++; $display("FAIL after_break: dv %0d byte %h errs %0d want 1 33 1", dv_a - dv0, a_byte, e_a - e0);
        end
    endtask

    task automatic test_glitch;
        int s0;
        s0 = dv_a + q_a + c_a + e_a + fe_a;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        #(20.0 * BIT_A);
        total++;
        if (dv_a + q_a + c_a + e_a + fe_a != s0) begin
            bad++; $display("FAIL glitch: got %0d pulses want 0", dv_a + q_a + c_a + e_a + fe_a - s0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int dv0, q0;
        logic [9:0] f;
        send_a(8'h43, 1'b1);
        dv0 = dv_a;
        f = {1'b1, 8'h5A, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx_a = f[i];
            #(BIT_A);
        end
        rx_a = f[5];
        #(80);
        rst  = 1'b1;
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({a_dv, a_ferr, a_query, a_clear, a_cmd_err, a_armed, a_byte} !== 14'h0) begin
            bad++; $display("FAIL reset_mid: got %b want all zero", {a_dv, a_ferr, a_query, a_clear, a_cmd_err, a_armed, a_byte});
        end
        rst = 1'b0;
        #(12.0 * BIT_A);
        total++;
        if (dv_a != dv0) begin bad++; $display("FAIL reset_mid_dv: got %0d want 0", dv_a - dv0); end
        q0 = q_a;
        send_a(8'h71, 1'b1);
        total++;
        if (q_a - q0 != 1 || a_byte !== 8'h71) begin
            bad++; $display("FAIL after_reset_q: queries %0d byte %h want 1 71", q_a - q0, a_byte);
        end
    endtask

    task automatic test_baud_tolerance;
        int dv0;
        dv0 = dv_b;
        send_b(8'h00, 870.0 * 1.03);
        total++;
        if (dv_b - dv0 != 1 || last_b !== 8'h00) begin
            bad++; $display("FAIL slow_00: dv %0d byte %h want 1 00", dv_b - dv0, last_b);
        end
        send_b(8'hFF, 870.0 * 1.03);
        total++;
        if (dv_b - dv0 != 2 || last_b !== 8'hFF) begin
            bad++; $display("FAIL slow_ff: dv %0d byte %h want 2 ff", dv_b - dv0, last_b);
        end
        send_b(8'h00, 870.0 * 0.97);
        total++;
        if (dv_b - dv0 != 3 || last_b !== 8'h00) begin
            bad++; $display("FAIL fast_00: dv %0d byte %h want 3 00", dv_b - dv0, last_b);
        end
        send_b(8'hFF, 870.0 * 0.97);
        total++;
        if (dv_b - dv0 != 4 || last_b !== 8'hFF || b_ferr !== 1'b0) begin
            bad++; $display("FAIL fast_ff: dv %0d byte %h want 4 ff", dv_b - dv0, last_b);
        end
    endtask

    initial begin
        test_reset();
        test_query();
        test_arm_clear();
        test_cmd_err();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_baud_tolerance();
        total++;
        if (viol_a != 0) begin bad++; $display("FAIL pulse_alignment: got %0d violations want 0", viol_a); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
